// File: rtl/sobel_calc_pkg.sv
// Shared pixel/window types and FSM encoding for the Sobel engine.
package image_pkg;

   localparam int PIXEL_BITS = 4;

   typedef logic [PIXEL_BITS-1:0] pixel_t;
   typedef pixel_t [2:0][2:0] window3_t;

   typedef enum logic [2:0] {
      IDLE,
      GRAD,
      ABS,
      SUM,
      DONE,
      HOLD
   } calc_state_t;

   function automatic logic [6:0] ext7(input pixel_t p);
      return {3'b000, p};
   endfunction

endpackage

// File: rtl/sobel_calc_if.sv
// Window handshake between the image buffer and the Sobel engine.
interface sobel_calc_if;
   import image_pkg::*;

   logic        calc_enable;
   window3_t    window_pixels;
   logic        calc_done;
   logic        result_valid;
   pixel_t      result_pixel;
   logic        edge_flag;
   logic [15:0] window_count;

   modport master (
      output calc_enable,
      output window_pixels,
      input  calc_done,
      input  result_valid,
      input  result_pixel,
      input  edge_flag,
      input  window_count
   );

   modport slave (
      input  calc_enable,
      input  window_pixels,
      output calc_done,
      output result_valid,
      output result_pixel,
      output edge_flag,
      output window_count
   );

endinterface

// File: rtl/sobel_calc_kernel.sv
// Combinational Sobel Gx/Gy over a 3x3 window, 7-bit two's complement.
module sobel_kernel
   import image_pkg::*;
(
   input  window3_t          win_i,
   output logic signed [6:0] gx_o,
   output logic signed [6:0] gy_o
);

   logic [6:0] xp, xn, yp, yn;

   assign xp = ext7(win_i[0][2])
             + (ext7(win_i[1][2]) << 1)
             + ext7(win_i[2][2]);
   assign xn = ext7(win_i[0][0])
             + (ext7(win_i[1][0]) << 1)
             + ext7(win_i[2][0]);
   assign yp = ext7(win_i[2][0])
             + (ext7(win_i[2][1]) << 1)
             + ext7(win_i[2][2]);
   assign yn = ext7(win_i[0][0])
             + (ext7(win_i[0][1]) << 1)
             + ext7(win_i[0][2]);

   // |G| <= 60 on each axis, so the 7-bit difference never wraps
   assign gx_o = xp - xn;
   assign gy_o = yp - yn;

endmodule

// File: rtl/sobel_calc.sv
// Sobel gradient engine: capture, grad, abs, sum/saturate, done pulse.
module sobel_calc
   import image_pkg::*;
#(
   parameter int SHIFT     = 3,
   parameter int THRESHOLD = 32
)
(
   input  logic         clk,
   input  logic         rst,
   sobel_calc_if.slave  bus
);

   localparam logic [7:0] THR8 = 8'(THRESHOLD);

   calc_state_t state_q, state_d;

   window3_t          win_q;
   logic signed [6:0] gx_d, gy_d, gx_q, gy_q;
   logic signed [6:0] gx_n, gy_n;
   logic [5:0]        ax_d, ay_d, ax_q, ay_q;
   logic [6:0]        mag, mag_sh;
   pixel_t            res_d, res_q;
   logic              flag_d, flag_q;
   logic              done_d, done_q;
   logic [15:0]       cnt_d, cnt_q;

   sobel_kernel u_kernel (
      .win_i (win_q),
      .gx_o  (gx_d),
      .gy_o  (gy_d)
   );

   assign gx_n   = -gx_q;
   assign gy_n   = -gy_q;
   assign ax_d   = gx_q[6] ? gx_n[5:0] : gx_q[5:0];
   assign ay_d   = gy_q[6] ? gy_n[5:0] : gy_q[5:0];
   assign mag    = {1'b0, ax_q} + {1'b0, ay_q};
   assign mag_sh = mag >> SHIFT;
   assign res_d  = (mag_sh > 7'd15) ? 4'hF : mag_sh[3:0];
   assign flag_d = ({1'b0, mag} >= THR8);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.calc_enable) state_d = GRAD;
         GRAD:    state_d = ABS;
         ABS:     state_d = SUM;
         SUM:     state_d = DONE;
         DONE:    state_d = HOLD;
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done_d = 1'b0;
      cnt_d  = cnt_q;
      if (state_q == DONE) begin
         done_d = 1'b1;
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q  <= '0;
         gx_q   <= '0;
         gy_q   <= '0;
         ax_q   <= '0;
         ay_q   <= '0;
         res_q  <= '0;
         flag_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (state_q == IDLE && bus.calc_enable)
            win_q <= bus.window_pixels;
         if (state_q == GRAD) begin
            gx_q <= gx_d;
            gy_q <= gy_d;
         end
         if (state_q == ABS) begin
            ax_q <= ax_d;
            ay_q <= ay_d;
         end
         if (state_q == SUM) begin
            res_q  <= res_d;
            flag_q <= flag_d;
         end
         done_q <= done_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.calc_done    = done_q;
   assign bus.result_valid = done_q;
   assign bus.result_pixel = res_q;
   assign bus.edge_flag    = flag_q;
   assign bus.window_count = cnt_q;

endmodule

// File: tb/tb_sobel_calc.sv
// Self-checking bench for sobel_calc: vector table, random model, corners.
module tb_sobel_calc;
   import image_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;

   sobel_calc_if bus ();
   sobel_calc_if bus2 ();

   sobel_calc u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sobel_calc #(.SHIFT(2), .THRESHOLD(32)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   typedef struct {
      window3_t   w;
      logic [3:0] pix;
      logic       flag;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic window3_t mkw(input int a00, a01, a02,
                                    input int a10, a11, a12,
                                    input int a20, a21, a22);
      window3_t w;
      w[0][0] = 4'(a00); w[0][1] = 4'(a01); w[0][2] = 4'(a02);
      w[1][0] = 4'(a10); w[1][1] = 4'(a11); w[1][2] = 4'(a12);
      w[2][0] = 4'(a20); w[2][1] = 4'(a21); w[2][2] = 4'(a22);
      return w;
   endfunction

   function automatic window3_t rand_win();
      window3_t w;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[r][c] = 4'($urandom_range(0, 15));
      return w;
   endfunction

   function automatic int px(input window3_t w, input int r, input int c);
      return int'(w[r][c]);
   endfunction

   // Reference straight from the Sobel definition in integer arithmetic
   function automatic void model(input window3_t w, input int sh,
                                 input int thr, output int pix,
                                 output int flag);
      int gx, gy, mag;
      gx = 0; gy = 0;
      for (int k = 0; k < 3; k++) begin
         gx += (k == 1 ? 2 : 1) * (px(w, k, 2) - px(w, k, 0));
         gy += (k == 1 ? 2 : 1) * (px(w, 2, k) - px(w, 0, k));
      end
      mag  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      pix  = (mag >> sh) > 15 ? 15 : (mag >> sh);
      flag = (mag >= thr) ? 1 : 0;
   endfunction

   task automatic run1(input window3_t w, input int ep, input int ef,
                       input string nm);
      int edges;
      bit seen;
      @(negedge clk);
      bus.calc_enable   = 1'b1;
      bus.window_pixels = w;
      edges = 0;
      seen  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 1) bus.window_pixels = rand_win();
         if (bus.calc_done) seen = 1;
      end
      bus.calc_enable = 1'b0;
      chk({nm, " done_seen"}, seen, 1);
      if (seen) begin
         exp_cnt++;
         chk({nm, " latency"}, edges - 1, 4);
         chk({nm, " valid"}, bus.result_valid, 1);
         chk({nm, " pixel"}, bus.result_pixel, ep);
         chk({nm, " flag"}, bus.edge_flag, ef);
         chk({nm, " count"}, bus.window_count, exp_cnt);
      end
      @(negedge clk);
      chk({nm, " done_pulse"}, bus.calc_done, 0);
   endtask

   vec_t vt[7];

   initial begin
      int p, f, gap, idx, edges;
      bit seen;
      window3_t cw[4];

      bus.calc_enable    = 1'b0;
      bus.window_pixels  = '0;
      bus2.calc_enable   = 1'b0;
      bus2.window_pixels = '0;

      vt[0] = '{mkw(0,0,0, 0,0,0, 0,0,0), 4'd0, 1'b0};
      vt[1] = '{mkw(0,0,15, 0,0,15, 0,0,15), 4'd7, 1'b1};
      vt[2] = '{mkw(15,0,0, 15,0,0, 15,0,0), 4'd7, 1'b1};
      vt[3] = '{mkw(0,0,15, 0,0,15, 15,15,15), 4'd11, 1'b1};
      vt[4] = '{mkw(0,0,8, 0,0,8, 0,0,8), 4'd4, 1'b1};
      vt[5] = '{mkw(0,0,8, 0,0,7, 0,0,8), 4'd3, 1'b0};
      vt[6] = '{mkw(0,0,1, 0,9,0, 0,0,0), 4'd0, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst done", bus.calc_done, 0);
      chk("rst valid", bus.result_valid, 0);
      chk("rst pixel", bus.result_pixel, 0);
      chk("rst flag", bus.edge_flag, 0);
      chk("rst count", bus.window_count, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run1(vt[i].w, int'(vt[i].pix), int'(vt[i].flag),
              $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++) begin
         cw[0] = rand_win();
         model(cw[0], 3, 32, p, f);
         run1(cw[0], p, f, $sformatf("rnd%0d", i));
      end

      // Abort while the window sits in ABS
      @(negedge clk);
      bus.calc_enable   = 1'b1;
      bus.window_pixels = vt[1].w;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.calc_enable = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      chk("abort done", bus.calc_done, 0);
      chk("abort pixel", bus.result_pixel, 0);
      chk("abort flag", bus.edge_flag, 0);
      chk("abort count", bus.window_count, 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.calc_done) seen = 1;
      end
      chk("abort no_done", seen, 0);

      // Four back-to-back windows with calc_enable held high
      cw[0] = vt[1].w;
      cw[1] = vt[3].w;
      cw[2] = rand_win();
      cw[3] = vt[2].w;
      @(negedge clk);
      bus.calc_enable   = 1'b1;
      bus.window_pixels = cw[0];
      idx = 0;
      gap = 0;
      for (int i = 0; i < 60 && idx < 4; i++) begin
         @(posedge clk);
         gap++;
         @(negedge clk);
         if (bus.calc_done) begin
            model(cw[idx], 3, 32, p, f);
            if (idx > 0) chk($sformatf("cont%0d gap", idx), gap, 6);
            chk($sformatf("cont%0d pixel", idx), bus.result_pixel, p);
            chk($sformatf("cont%0d flag", idx), bus.edge_flag, f);
            gap = 0;
            idx++;
            if (idx < 4) bus.window_pixels = cw[idx];
         end
      end
      bus.calc_enable = 1'b0;
      chk("cont windows", idx, 4);
      chk("cont count", bus.window_count, 4);

      // SHIFT=2 instance: mag 90 saturates
      @(negedge clk);
      bus2.calc_enable   = 1'b1;
      bus2.window_pixels = mkw(0,0,15, 0,0,15, 0,15,15);
      seen  = 0;
      edges = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus2.calc_done) seen = 1;
      end
      bus2.calc_enable = 1'b0;
      chk("shift2 done_seen", seen, 1);
      chk("shift2 latency", edges - 1, 4);
      chk("shift2 pixel", bus2.result_pixel, 15);
      chk("shift2 flag", bus2.edge_flag, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
